// File: rtl/thiele_coproc_pkg.sv
// Shared types and constants for the Thiele coprocessor bridge.
// Holds the FSM encoding, command-kind codes and the default timeout payload.
package thiele_coproc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    localparam logic        KIND_LOGIC       = 1'b0;
    localparam logic        KIND_PY          = 1'b1;
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADC0DE;

    typedef struct packed {
        logic        kind;
        logic [31:0] addr;
    } cmd_t;

endpackage

// File: rtl/thiele_coproc_bridge.sv
// Arbitrates CPU logic/Python requests onto one coprocessor command/response channel.
// Latency: grant, ISSUE until cp_ready, WAIT until rsp_valid or TIMEOUT_CYCLES, one-cycle ack.
// Backpressure: cp_ready low holds the command stable in ISSUE; one request in flight at a time.
module thiele_coproc_bridge
    import thiele_coproc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        logic_req,
    input  logic [31:0] logic_addr,
    output logic        logic_ack,
    output logic [31:0] logic_data,
    input  logic        py_req,
    input  logic [31:0] py_code_addr,
    output logic        py_ack,
    output logic [31:0] py_result,
    output logic        cp_valid,
    output logic        cp_kind,
    output logic [31:0] cp_addr,
    input  logic        cp_ready,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    output logic        busy,
    output logic [31:0] timeout_count
);

    localparam int            CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state, state_nxt;
    cmd_t              cmd;
    logic [CNT_W-1:0]  wait_cnt;
    logic              last_py;
    logic              logic_armed, py_armed;
    logic              logic_elig, py_elig;
    logic              grant, grant_py;
    logic              expire, finish;
    logic [31:0]       ack_dat;

    assign logic_elig = logic_req & logic_armed;
    assign py_elig    = py_req & py_armed;
    // Python wins only if logic is not competing or logic was granted last.
    assign grant_py   = py_elig & (~logic_elig | ~last_py);
    assign grant      = logic_elig | py_elig;

    assign expire  = (state == ST_WAIT) & ~rsp_valid & (wait_cnt == CNT_LAST);
    assign finish  = (state == ST_WAIT) & (rsp_valid | expire);
    assign ack_dat = rsp_valid ? rsp_data : ERR_DATA;

    assign cp_kind = cmd.kind;
    assign cp_addr = cmd.addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cp_valid  = 1'b0;
        logic_ack = 1'b0;
        py_ack    = 1'b0;
        busy      = 1'b1;
        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (grant) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                cp_valid = 1'b1;
                if (cp_ready) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (finish) state_nxt = ST_ACK;
            end
            ST_ACK: begin
                logic_ack = (cmd.kind == KIND_LOGIC);
                py_ack    = (cmd.kind == KIND_PY);
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd           <= '0;
            wait_cnt      <= '0;
            last_py       <= 1'b1;
            logic_armed   <= 1'b1;
            py_armed      <= 1'b1;
            logic_data    <= '0;
            py_result     <= '0;
            timeout_count <= '0;
        end else begin
            if (state == ST_IDLE && grant) begin
                cmd.kind <= grant_py ? KIND_PY : KIND_LOGIC;
                cmd.addr <= grant_py ? py_code_addr : logic_addr;
                last_py  <= grant_py;
            end

            if (state == ST_ISSUE) begin
                wait_cnt <= '0;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (finish) begin
                if (cmd.kind == KIND_LOGIC) logic_data <= ack_dat;
                else                        py_result  <= ack_dat;
            end

            if (expire && timeout_count != '1) begin
                timeout_count <= timeout_count + 32'd1;
            end

            // Clearing at ack takes priority so a req still high cannot be served twice.
            if (state == ST_ACK && cmd.kind == KIND_LOGIC) logic_armed <= 1'b0;
            else if (!logic_req)                           logic_armed <= 1'b1;

            if (state == ST_ACK && cmd.kind == KIND_PY) py_armed <= 1'b0;
            else if (!py_req)                           py_armed <= 1'b1;
        end
    end

endmodule

// File: tb/tb_thiele_coproc_bridge.sv
// Self-checking bench for thiele_coproc_bridge with a reactive coprocessor model.
module tb_thiele_coproc_bridge;

    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hDEADC0DE;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        logic_req = 1'b0;
    logic [31:0] logic_addr = '0;
    logic        logic_ack;
    logic [31:0] logic_data;
    logic        py_req = 1'b0;
    logic [31:0] py_code_addr = '0;
    logic        py_ack;
    logic [31:0] py_result;
    logic        cp_valid;
    logic        cp_kind;
    logic [31:0] cp_addr;
    logic        cp_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        busy;
    logic [31:0] timeout_count;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] exp_ld, exp_pr, exp_to;

    thiele_coproc_bridge #(
        .TIMEOUT_CYCLES(TO),
        .ERR_DATA      (ERR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .logic_req    (logic_req),
        .logic_addr   (logic_addr),
        .logic_ack    (logic_ack),
        .logic_data   (logic_data),
        .py_req       (py_req),
        .py_code_addr (py_code_addr),
        .py_ack       (py_ack),
        .py_result    (py_result),
        .cp_valid     (cp_valid),
        .cp_kind      (cp_kind),
        .cp_addr      (cp_addr),
        .cp_ready     (cp_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .busy         (busy),
        .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        logic_req = 0; py_req = 0; cp_ready = 0; rsp_valid = 0; rsp_data = 0;
        logic_addr = 0; py_code_addr = 0;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        exp_ld = 0; exp_pr = 0; exp_to = 0;
    endtask

    // Plays the coprocessor: accepts after r stalled valid cycles, responds in WAIT index d.
    // Returns observations only; callers judge them.
    task automatic serve_one(input int r, input int d, input logic [31:0] dat, input bit drop_req,
                             output bit ks, output logic [31:0] as, output bit unstable,
                             output int ac, output bit al, output bit ap,
                             output logic [31:0] ld, output logic [31:0] pr, output int vc);
        bit hs, in_wait, first;
        int widx, n;
        ks = 0; as = 0; unstable = 0; ac = -1; al = 0; ap = 0; ld = 0; pr = 0; vc = 0;
        hs = 0; in_wait = 0; first = 1; widx = 0; n = 0;
        while (ac < 0 && n < 200) begin
            if (cp_valid) begin
                if (first) begin
                    ks = cp_kind; as = cp_addr; first = 0;
                end else if (cp_kind !== ks || cp_addr !== as) begin
                    unstable = 1;
                end
                cp_ready = (vc >= r);
                hs = cp_ready;
                vc++;
            end else begin
                cp_ready = 1'($urandom_range(0, 1));
                hs = 0;
            end
            if (in_wait) begin
                rsp_valid = (widx == d);
                widx++;
            end else begin
                rsp_valid = ($urandom_range(0, 3) == 0);
            end
            rsp_data = (rsp_valid && in_wait) ? dat : $urandom;
            @(posedge clk); #1; n++;
            if (hs) in_wait = 1;
            if (drop_req && n == 1) begin logic_req = 0; py_req = 0; end
            if (logic_ack || py_ack) begin
                ac = n; al = logic_ack; ap = py_ack; ld = logic_data; pr = py_result;
            end
        end
        cp_ready = 0; rsp_valid = 0;
    endtask

    task automatic test_reset();
        logic [132:0] outs;
        apply_reset();
        outs = {logic_ack, py_ack, cp_valid, cp_kind, cp_addr, logic_data, py_result, busy, timeout_count};
        tests_run++;
        if (outs !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
    endtask

    task automatic test_logic_only();
        bit ks, un, al, ap; logic [31:0] as, ld, pr; int ac, vc; bit regrant;
        logic_req = 1; logic_addr = 32'h10;
        serve_one(0, 1, 32'hABCD1234, 0, ks, as, un, ac, al, ap, ld, pr, vc);
        tests_run++;
        if ({ks, as} !== {1'b0, 32'h10}) begin
            tests_failed++; $display("FAIL logic_cmd: got kind %b addr %h expected 0 00000010", ks, as);
        end
        tests_run++;
        if (ac !== 4) begin
            tests_failed++; $display("FAIL min_latency: got ack after edge %0d expected 4", ac);
        end
        tests_run++;
        if ({al, ap, ld} !== {2'b10, 32'hABCD1234}) begin
            tests_failed++; $display("FAIL logic_ack_data: got %b%b %h expected 10 abcd1234", al, ap, ld);
        end
        exp_ld = 32'hABCD1234;
        regrant = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (cp_valid || busy || logic_ack) regrant = 1;
        end
        tests_run++;
        if (regrant !== 1'b0) begin
            tests_failed++; $display("FAIL no_double_serve: got regrant %b expected 0", regrant);
        end
        logic_req = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_round_robin();
        bit ks1, ks2, un, al1, ap1, al2, ap2, extra; logic [31:0] as1, as2, ld, pr, la, pa;
        int ac, vc;
        apply_reset();
        la = $urandom; pa = $urandom;
        logic_req = 1; py_req = 1; logic_addr = la; py_code_addr = pa;
        serve_one(0, 0, 32'h1111_0000, 0, ks1, as1, un, ac, al1, ap1, ld, pr, vc);
        serve_one(0, 2, 32'h2222_0000, 0, ks2, as2, un, ac, al2, ap2, ld, pr, vc);
        tests_run++;
        if ({ks1, as1, ks2, as2} !== {1'b0, la, 1'b1, pa}) begin
            tests_failed++;
            $display("FAIL rr_order: got %b/%h then %b/%h expected 0/%h then 1/%h", ks1, as1, ks2, as2, la, pa);
        end
        tests_run++;
        if ({al1, ap1, al2, ap2} !== 4'b1001) begin
            tests_failed++; $display("FAIL rr_acks: got %b%b %b%b expected 10 01", al1, ap1, al2, ap2);
        end
        exp_ld = 32'h1111_0000; exp_pr = 32'h2222_0000;
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (cp_valid || logic_ack || py_ack) extra = 1;
        end
        tests_run++;
        if (extra !== 1'b0) begin
            tests_failed++; $display("FAIL rr_single_each: got extra grant %b expected 0", extra);
        end
        logic_req = 0; py_req = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_timeout();
        bit ks, un, al, ap; logic [31:0] as, ld, pr; int ac, vc;
        apply_reset();
        py_req = 1; py_code_addr = 32'h0000_2000;
        serve_one(0, 1000, 32'h5555_5555, 0, ks, as, un, ac, al, ap, ld, pr, vc);
        tests_run++;
        if (ac !== 10) begin
            tests_failed++; $display("FAIL timeout_latency: got ack after edge %0d expected 10", ac);
        end
        tests_run++;
        if ({ap, pr, timeout_count} !== {1'b1, ERR, 32'd1}) begin
            tests_failed++; $display("FAIL timeout_result: got %b %h cnt %0d expected 1 deadc0de cnt 1", ap, pr, timeout_count);
        end
        exp_pr = ERR; exp_to = 1;
        py_req = 0;
        for (int i = 0; i < 2; i++) begin
            rsp_valid = 1; rsp_data = $urandom;
            @(posedge clk); #1;
        end
        rsp_valid = 0;
        tests_run++;
        if ({logic_ack, py_ack, busy, py_result, timeout_count} !== {3'b000, ERR, 32'd1}) begin
            tests_failed++; $display("FAIL late_rsp_ignored: got %b%b%b %h %0d expected 000 deadc0de 1", logic_ack, py_ack, busy, py_result, timeout_count);
        end
    endtask

    task automatic test_tie();
        bit ks, un, al, ap; logic [31:0] as, ld, pr, dat; int ac, vc;
        dat = $urandom;
        logic_req = 1; logic_addr = $urandom;
        serve_one(0, TO - 1, dat, 0, ks, as, un, ac, al, ap, ld, pr, vc);
        tests_run++;
        if ({al, ld, timeout_count} !== {1'b1, dat, exp_to} || ac !== 10) begin
            tests_failed++; $display("FAIL tie_rsp_wins: got %b %h cnt %0d edge %0d expected 1 %h cnt %0d edge 10", al, ld, timeout_count, ac, dat, exp_to);
        end
        exp_ld = dat;
        logic_req = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        bit ks, un, al, ap; logic [31:0] as, ld, pr, a; int ac, vc;
        a = $urandom;
        py_req = 1; py_code_addr = a;
        serve_one(5, 1, 32'h0BAD_F00D, 0, ks, as, un, ac, al, ap, ld, pr, vc);
        tests_run++;
        if ({un, ks, as} !== {1'b0, 1'b1, a} || vc !== 6) begin
            tests_failed++; $display("FAIL bp_stable: got unstable %b kind %b addr %h valid %0d expected 0 1 %h 6", un, ks, as, vc, a);
        end
        tests_run++;
        if (ac !== 9 || pr !== 32'h0BAD_F00D) begin
            tests_failed++; $display("FAIL bp_result: got edge %0d %h expected 9 0badf00d", ac, pr);
        end
        exp_pr = 32'h0BAD_F00D;
        py_req = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        logic [132:0] outs; bit seen_ack;
        bit ks, un, al, ap; logic [31:0] as, ld, pr, dat; int ac, vc;
        py_req = 1; py_code_addr = $urandom; cp_ready = 1; rsp_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({busy, cp_valid} !== 2'b10) begin
            tests_failed++; $display("FAIL mid_wait: got busy %b cp_valid %b expected 1 0", busy, cp_valid);
        end
        rst_n = 0;
        #1;
        outs = {logic_ack, py_ack, cp_valid, cp_kind, cp_addr, logic_data, py_result, busy, timeout_count};
        tests_run++;
        if (outs !== '0) begin
            tests_failed++; $display("FAIL reset_mid_outputs: got %h expected 0", outs);
        end
        seen_ack = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (logic_ack || py_ack) seen_ack = 1;
        end
        py_req = 0; cp_ready = 0;
        rst_n = 1;
        exp_ld = 0; exp_pr = 0; exp_to = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if (logic_ack || py_ack) seen_ack = 1;
        end
        tests_run++;
        if (seen_ack !== 1'b0) begin
            tests_failed++; $display("FAIL reset_no_ack: got ack %b expected 0", seen_ack);
        end
        dat = $urandom;
        logic_req = 1; logic_addr = 32'h0000_0444;
        serve_one(0, 2, dat, 0, ks, as, un, ac, al, ap, ld, pr, vc);
        tests_run++;
        if ({al, ap, ld, as} !== {2'b10, dat, 32'h0000_0444} || ac !== 5) begin
            tests_failed++; $display("FAIL post_reset_txn: got %b%b %h %h edge %0d expected 10 %h 00000444 edge 5", al, ap, ld, as, ac, dat);
        end
        exp_ld = dat;
        logic_req = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        bit k, drop, ks, un, al, ap, stale_bad;
        logic [31:0] a, dat, as, ld, pr, exp_dat;
        int r, d, ac, vc, exp_lat;
        for (int t = 0; t < 24; t++) begin
            k = 1'($urandom_range(0, 1));
            a = $urandom; dat = $urandom;
            r = $urandom_range(0, 3); d = $urandom_range(0, 10);
            drop = ($urandom_range(0, 3) == 0);
            if (k) begin py_req = 1; py_code_addr = a; logic_addr = $urandom; end
            else   begin logic_req = 1; logic_addr = a; py_code_addr = $urandom; end
            // Response in WAIT slot 0..TO-1 wins (including the expiry slot); otherwise ERR.
            exp_dat = (d < TO) ? dat : ERR;
            exp_lat = r + ((d < TO) ? d : TO - 1) + 3;
            if (d >= TO) exp_to = exp_to + 1;
            if (k) exp_pr = exp_dat; else exp_ld = exp_dat;
            serve_one(r, d, dat, drop, ks, as, un, ac, al, ap, ld, pr, vc);
            tests_run++;
            if ({ks, as, un} !== {k, a, 1'b0}) begin
                tests_failed++; $display("FAIL rand_cmd[%0d]: got %b %h unstable %b expected %b %h 0", t, ks, as, un, k, a);
            end
            tests_run++;
            if (ac !== exp_lat || {al, ap} !== {~k, k}) begin
                tests_failed++; $display("FAIL rand_ack[%0d]: got edge %0d acks %b%b expected edge %0d acks %b%b", t, ac, al, ap, exp_lat, ~k, k);
            end
            tests_run++;
            if ({ld, pr, timeout_count} !== {exp_ld, exp_pr, exp_to}) begin
                tests_failed++; $display("FAIL rand_data[%0d]: got %h %h %0d expected %h %h %0d", t, ld, pr, timeout_count, exp_ld, exp_pr, exp_to);
            end
            logic_req = 0; py_req = 0;
            stale_bad = 0;
            for (int i = 0; i < 2; i++) begin
                rsp_valid = 1'($urandom_range(0, 1)); rsp_data = $urandom;
                @(posedge clk); #1;
                if (logic_ack || py_ack || busy) stale_bad = 1;
            end
            rsp_valid = 0;
            tests_run++;
            if (stale_bad !== 1'b0 || {logic_data, py_result, timeout_count} !== {exp_ld, exp_pr, exp_to}) begin
                tests_failed++; $display("FAIL rand_idle[%0d]: got extra %b %h %h %0d expected 0 %h %h %0d", t, stale_bad, logic_data, py_result, timeout_count, exp_ld, exp_pr, exp_to);
            end
        end
    endtask

    initial begin
        test_reset();
        test_logic_only();
        test_round_robin();
        test_timeout();
        test_tie();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/thiele_coproc_bridge.md
THIELE_COPROC_BRIDGE -- requirements
Module: thiele_coproc_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: number of WAIT cycles allowed before a request is failed.
REQ-002 SHALL have parameter ERR_DATA, default 32'hDEADC0DE: value returned to the CPU on timeout.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port logic_req  input  1  CPU logic-engine request level.
REQ-006 SHALL have port logic_addr  input  32  logic-engine operand address.
REQ-007 SHALL have port logic_ack  output  1  one-cycle completion pulse for a logic request.
REQ-008 SHALL have port logic_data  output  32  logic-engine result; valid while logic_ack is high.
REQ-009 SHALL have port py_req  input  1  CPU Python-exec request level.
REQ-010 SHALL have port py_code_addr  input  32  Python code address.
REQ-011 SHALL have port py_ack  output  1  one-cycle completion pulse for a Python request.
REQ-012 SHALL have port py_result  output  32  Python result; valid while py_ack is high.
REQ-013 SHALL have port cp_valid  output  1  coprocessor command valid.
REQ-014 SHALL have port cp_kind  output  1  command kind: 0 = logic, 1 = Python.
REQ-015 SHALL have port cp_addr  output  32  command address.
REQ-016 SHALL have port cp_ready  input  1  coprocessor accepts the command.
REQ-017 SHALL have port rsp_valid  input  1  coprocessor response strobe.
REQ-018 SHALL have port rsp_data  input  32  response payload.
REQ-019 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-020 SHALL have port timeout_count  output  32  number of timed-out requests; saturates at 32'hFFFFFFFF.

Function
REQ-021 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> ACK -> IDLE, one request in flight at a time.
REQ-022 IDLE: a source is eligible when its req is high and its armed flag is set; with no eligible source the FSM SHALL stay in IDLE.
REQ-023 With both sources eligible, the bridge SHALL grant round-robin, serving the source not granted last; after reset, logic wins first.
REQ-024 On a grant the bridge SHALL latch kind and address and enter ISSUE, with cp_valid high on the next cycle.
REQ-025 ISSUE: cp_valid, cp_kind and cp_addr SHALL hold stable until a cycle with cp_valid and cp_ready both high, then enter WAIT with cp_valid low.
REQ-026 WAIT: the cycle counter SHALL reset to 0 on entry and increment each cycle; rsp_valid SHALL latch rsp_data and enter ACK.
REQ-027 WAIT: if the counter equals TIMEOUT_CYCLES-1 with rsp_valid low, the bridge SHALL latch ERR_DATA, increment timeout_count and enter ACK.
REQ-028 If rsp_valid and timeout expiry fall in the same cycle, the response SHALL win and timeout_count SHALL NOT change.
REQ-029 ACK: exactly one cycle of the granted source's ack, with its data output carrying the latched value, then IDLE.
REQ-030 logic_data and py_result SHALL hold their last value between acks.
REQ-031 The served source's armed flag SHALL clear at ack, and SHALL set again only once its req is sampled low; this prevents a double-serve from a req still high after ack.
REQ-032 rsp_valid outside WAIT (stale or late after timeout) SHALL be ignored.
REQ-033 Minimum latency SHALL be: req high at edge N with cp_ready tied high, rsp_valid at edge N+3 -> ack high after edge N+4.
REQ-034 Request inputs SHALL NOT be re-sampled between grant and ACK; a req dropping mid-flight does not abort the transaction.

Reset
REQ-035 Reset SHALL set: state IDLE; all outputs 0 (logic_ack, py_ack, cp_valid, cp_kind, cp_addr, logic_data, py_result, busy, timeout_count); both armed flags 1; last-grant = Python.
REQ-036 Reset mid-transaction SHALL abandon the request immediately, with no ack issued.

Structure
REQ-037 Package thiele_coproc_pkg SHALL hold the state encoding, the KIND_LOGIC/KIND_PY constants and the default ERR_DATA.
REQ-038 The block SHALL be a single module with no sub-module; the arbiter is a single last-grant flip-flop.

Verification
REQ-039 Logic only: logic_req=1, logic_addr=32'h10, cp_ready=1, rsp_data=32'hABCD1234 after 2 cycles -> cp_kind=0, cp_addr=32'h10, one logic_ack pulse, logic_data=32'hABCD1234.
REQ-040 Simultaneous requests, both held high -> logic served first, then Python; cp_addr sequence = logic_addr then py_code_addr; exactly one ack each.
REQ-041 Python request with rsp_valid never asserted, TIMEOUT_CYCLES=8 -> py_ack after 8 WAIT cycles, py_result=32'hDEADC0DE, timeout_count=1.
REQ-042 rsp_valid on the exact expiry cycle -> rsp_data returned and timeout_count unchanged; a late rsp_valid in IDLE -> ignored.
REQ-043 cp_ready held low 5 cycles -> cp_valid, cp_kind and cp_addr stable for all 5; a req held high 3 cycles after ack -> no second grant.
REQ-044 rst_n low during WAIT -> outputs 0, no ack, and a fresh request is served normally afterwards.
